// File: rtl/mult32_sequencer_if.sv
// Operand/product handshake bundle for the 32x32 multiply sequencer.
// The slave side is the sequencer; the master side feeds operands and drains products.
interface mult32_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        busy;
   logic [15:0] op_count;

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, product, busy, op_count
   );

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, product, busy, op_count
   );
endinterface

// File: rtl/mult32_sequencer.sv
// 32x32 -> 64 unsigned multiplier built from one 16x16 multiplier reused over four steps,
// with valid/ready handshakes on both operand and product sides.
module multiplier_16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);
   assign p = {16'd0, a} * {16'd0, b};
endmodule

module mult32_sequencer (
   input  logic                clk,
   input  logic                reset,
   mult32_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] acc_q, acc_d;
   logic [1:0]  step_q, step_d;
   logic [63:0] product_q, product_d;
   logic [15:0] op_count_q, op_count_d;

   logic [15:0] mult_a;
   logic [15:0] mult_b;
   logic [31:0] mult_p;
   logic [63:0] partial;
   logic [63:0] acc_sum;

   // step[1] picks the A half, step[0] picks the B half: lo*lo, lo*hi, hi*lo, hi*hi.
   assign mult_a = step_q[1] ? a_q[31:16] : a_q[15:0];
   assign mult_b = step_q[0] ? b_q[31:16] : b_q[15:0];

   multiplier_16 u_mult (
      .a (mult_a),
      .b (mult_b),
      .p (mult_p)
   );

   always_comb begin
      partial = 64'd0;
      case (step_q)
         2'd0:    partial = {32'd0, mult_p};
         2'd1,
         2'd2:    partial = {16'd0, mult_p, 16'd0};
         default: partial = {mult_p, 32'd0};
      endcase
   end

   assign acc_sum = acc_q + partial;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      step_d     = step_q;
      product_d  = product_q;
      op_count_d = op_count_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.A;
               b_d     = bus.B;
               acc_d   = 64'd0;
               step_d  = 2'd0;
               state_d = MUL;
            end
         end
         MUL: begin
            acc_d  = acc_sum;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               product_d = acc_sum;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               op_count_d = op_count_q + 16'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         acc_q      <= 64'd0;
         step_q     <= 2'd0;
         product_q  <= 64'd0;
         op_count_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         step_q     <= step_d;
         product_q  <= product_d;
         op_count_q <= op_count_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.product   = product_q;
   assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_mult32_sequencer.sv
// Self-checking bench for mult32_sequencer: directed corner cases plus randomized
// operations against a plain 64-bit arithmetic reference.
module tb_mult32_sequencer;
   logic clk = 1'b0;
   logic reset;

   mult32_sequencer_if bus ();

   mult32_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_count;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      return 64'(a) * 64'(b);
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_count = 16'd0;
   endtask

   // Starts and ends at a negedge with the DUT in IDLE.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                         input bit rdy_mul, output logic [63:0] prod, output int lat,
                         output bit ready_ok);
      bus.in_valid  = 1'b1;
      bus.A         = a;
      bus.B         = b;
      bus.out_ready = rdy_mul;
      ready_ok = (bus.in_ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.A = $urandom;
      bus.B = $urandom;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 12) begin
         if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      bus.in_valid = 1'b0;
      prod = bus.product;
      bus.out_ready = 1'b0;
      repeat (hold) @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      logic [63:0] prod;
      int lat;
      bit ok;
      reset = 1'b1;
      bus.in_valid = 1'b1;
      bus.A = $urandom;
      bus.B = $urandom;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_vec++; if (bus.product !== 64'd0) begin n_err++; $display("FAIL reset_product: got %h want 0", bus.product); end
      n_vec++; if (bus.op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count: got %h want 0", bus.op_count); end
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      exp_count = 16'd0;
      @(negedge clk);
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
      run_op(32'hDEADBEEF, 32'h12345678, 0, 1'b0, prod, lat, ok);
      $display("reset-test op a=deadbeef b=12345678 product=%h", prod);
      reset = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      n_vec++; if (bus.product !== 64'd0) begin n_err++; $display("FAIL reset2_product: got %h want 0", bus.product); end
      n_vec++; if (bus.op_count !== 16'd0) begin n_err++; $display("FAIL reset2_op_count: got %h want 0", bus.op_count); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset2_busy: got %b want 0", bus.busy); end
      exp_count = 16'd0;
   endtask

   task automatic test_basic();
      logic [63:0] prod;
      int lat;
      bit ok;
      run_op(32'd3, 32'd5, 0, 1'b1, prod, lat, ok);
      exp_count++;
      $display("basic op a=3 b=5 product=%h lat=%0d", prod, lat);
      n_vec++; if (prod !== 64'h000000000000000F) begin n_err++; $display("FAIL basic_product: got %h want 000000000000000f", prod); end
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
      n_vec++; if (!ok) begin n_err++; $display("FAIL basic_in_ready: got wrong in_ready around accept, want 1 then 0"); end
      n_vec++; if (bus.op_count !== 16'd1) begin n_err++; $display("FAIL basic_op_count: got %0d want 1", bus.op_count); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_after: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_corners();
      logic [31:0] ta [4] = '{32'hFFFFFFFF, 32'h00010000, 32'h00000000, 32'h89ABCDEF};
      logic [31:0] tb [4] = '{32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 32'h00000001};
      logic [63:0] te [4] = '{64'hFFFFFFFE00000001, 64'h0000000100000000, 64'h0, 64'h0000000089ABCDEF};
      logic [63:0] prod;
      int lat;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         run_op(ta[i], tb[i], i, i[0], prod, lat, ok);
         exp_count++;
         $display("corner op a=%h b=%h product=%h lat=%0d", ta[i], tb[i], prod, lat);
         n_vec++; if (prod !== te[i]) begin n_err++; $display("FAIL corner_product[%0d]: got %h want %h", i, prod, te[i]); end
         n_vec++; if (lat !== 4) begin n_err++; $display("FAIL corner_latency[%0d]: got %0d want 4", i, lat); end
         n_vec++; if (bus.op_count !== exp_count) begin n_err++; $display("FAIL corner_op_count[%0d]: got %0d want %0d", i, bus.op_count, exp_count); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A = 32'hFFFF0000;
      bus.B = 32'h0000FFFF;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL bp_latency: got %0d want 4", lat); end
      for (int c = 0; c < 3; c++) begin
         n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, bus.out_valid); end
         n_vec++; if (bus.product !== 64'h0000FFFE00010000) begin n_err++; $display("FAIL bp_product[%0d]: got %h want 0000fffe00010000", c, bus.product); end
         @(negedge clk);
      end
      n_vec++; if (bus.op_count !== exp_count) begin n_err++; $display("FAIL bp_op_count_held: got %0d want %0d", bus.op_count, exp_count); end
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid_before_hs: got %b want 1", bus.out_valid); end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      exp_count++;
      $display("backpressure op a=ffff0000 b=0000ffff product=%h", bus.product);
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_out_valid_after_hs: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.op_count !== exp_count) begin n_err++; $display("FAIL bp_op_count: got %0d want %0d", bus.op_count, exp_count); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_operand_change();
      logic [31:0] a = 32'hCAFEF00D;
      logic [31:0] b = 32'h0BADBEEF;
      int lat;
      bit ok = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A = a;
      bus.B = b;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.A = 32'd0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 12) begin
         if (bus.in_ready !== 1'b0) ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      bus.in_valid = 1'b0;
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL opchg_latency: got %0d want 4", lat); end
      n_vec++; if (!ok) begin n_err++; $display("FAIL opchg_in_ready: got in_ready=1 during MUL want 0"); end
      n_vec++; if (bus.product !== ref_mul(a, b)) begin n_err++; $display("FAIL opchg_product: got %h want %h", bus.product, ref_mul(a, b)); end
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      exp_count++;
      $display("operand-change op a=%h b=%h product=%h", a, b, bus.product);
      n_vec++; if (bus.op_count !== exp_count) begin n_err++; $display("FAIL opchg_op_count: got %0d want %0d", bus.op_count, exp_count); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL opchg_busy: got %b want 0", bus.busy); end
      @(negedge clk);
      n_vec++; if (bus.product !== ref_mul(a, b)) begin n_err++; $display("FAIL opchg_product_retained: got %h want %h", bus.product, ref_mul(a, b)); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] prod;
      int lat;
      bit ok;
      bit seen = 1'b0;
      apply_reset();
      bus.in_valid = 1'b1;
      bus.A = 32'h12345678;
      bus.B = 32'h9ABCDEF0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %b want 1", bus.in_ready); end
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.product !== 64'd0) begin n_err++; $display("FAIL rmid_product: got %h want 0", bus.product); end
      n_vec++; if (bus.op_count !== 16'd0) begin n_err++; $display("FAIL rmid_op_count: got %0d want 0", bus.op_count); end
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen = 1'b1;
      end
      n_vec++; if (seen) begin n_err++; $display("FAIL rmid_no_output: got out_valid=1 after discard want 0"); end
      run_op(32'h0000ABCD, 32'h00012345, 0, 1'b0, prod, lat, ok);
      exp_count++;
      $display("post-reset op a=0000abcd b=00012345 product=%h", prod);
      n_vec++; if (prod !== ref_mul(32'h0000ABCD, 32'h00012345)) begin n_err++; $display("FAIL rmid_new_product: got %h want %h", prod, ref_mul(32'h0000ABCD, 32'h00012345)); end
      n_vec++; if (bus.op_count !== 16'd1) begin n_err++; $display("FAIL rmid_new_op_count: got %0d want 1", bus.op_count); end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [63:0] prod, want;
      int lat, hold;
      bit ok;
      apply_reset();
      for (int i = 0; i < 10000; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'd0;
         if ($urandom_range(0, 15) == 0) b = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'd1;
         hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
         run_op(a, b, hold, 1'($urandom_range(0, 1)), prod, lat, ok);
         exp_count++;
         want = ref_mul(a, b);
         $display("rand op %0d a=%h b=%h product=%h hold=%0d", i, a, b, prod, hold);
         n_vec++; if (prod !== want) begin n_err++; $display("FAIL rand_product[%0d]: got %h want %h", i, prod, want); end
         n_vec++; if (lat !== 4) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want 4", i, lat); end
         n_vec++; if (!ok) begin n_err++; $display("FAIL rand_in_ready[%0d]: got wrong in_ready want 1 at accept then 0", i); end
         n_vec++; if (bus.op_count !== exp_count) begin n_err++; $display("FAIL rand_op_count[%0d]: got %0d want %0d", i, bus.op_count, exp_count); end
      end
      n_vec++; if (bus.op_count !== 16'(10000 % 65536)) begin n_err++; $display("FAIL rand_final_op_count: got %0d want %0d", bus.op_count, 10000 % 65536); end
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.A = 32'd0;
      bus.B = 32'd0;
      exp_count = 16'd0;
      test_reset();
      test_basic();
      test_corners();
      test_backpressure();
      test_operand_change();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
